// File: rtl/id_forward_scoreboard_pkg.sv
// Shared types and constants for the decode-stage forwarding scoreboard.
// Entry fields are sized for the widest supported configuration; narrower ports zero-extend.
package id_forward_scoreboard_pkg;

  localparam int SB_ADDR_W = 8;
  localparam int SB_LAT_W  = 4;

  localparam int SLOT_EX  = 0;
  localparam int SLOT_MEM = 1;
  localparam int SLOT_WB  = 2;

  localparam int READY_ALU  = 0;
  localparam int READY_LOAD = 1;

  typedef struct packed {
    logic                 valid;
    logic [SB_ADDR_W-1:0] dst;
    logic [SB_LAT_W-1:0]  rdy;
  } sbEntry_t;

  function automatic sbEntry_t makeEntry(input logic valid, input logic [SB_ADDR_W-1:0] dst,
                                         input logic [SB_LAT_W-1:0] rdy);
    sbEntry_t e;
    e.valid = valid;
    e.dst   = dst;
    e.rdy   = rdy;
    return e;
  endfunction

endpackage

// File: rtl/id_forward_scoreboard_fwd_port_resolve.sv
// One decode read port: finds the youngest in-flight producer of its register and
// either forwards that slot's result, falls back to the register file, or flags a hazard.
module fwd_port_resolve
  import id_forward_scoreboard_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 3
) (
  input  logic                    en,
  input  logic [ADDR_W-1:0]       addr,
  input  logic [DATA_W-1:0]       rfData,
  input  logic [DEPTH*DATA_W-1:0] stageData,
  input  sbEntry_t [DEPTH-1:0]    entries,
  output logic [DATA_W-1:0]       data,
  output logic                    fwd,
  output logic                    hazard
);

  logic                 hit;
  int                   hitIdx;
  logic [SB_LAT_W-1:0]  hitRdy;
  logic [SB_ADDR_W-1:0] addrExt;

  assign addrExt = SB_ADDR_W'(addr);

  // NOTE: every variable written here gets a default first, so no path leaves a latch.
  always_comb begin
    hit    = 1'b0;
    hitIdx = 0;
    hitRdy = '0;
    // Scan oldest to youngest so the lowest matching slot is the one left standing.
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (entries[k].valid && entries[k].dst == addrExt) begin
        hit    = 1'b1;
        hitIdx = k;
        hitRdy = entries[k].rdy;
      end
    end

    data   = rfData;
    fwd    = 1'b0;
    hazard = 1'b0;
    if (en && addr != '0 && hit) begin
      if (hitIdx >= int'(hitRdy)) begin
        data = stageData[hitIdx*DATA_W +: DATA_W];
        fwd  = 1'b1;
      end else begin
        hazard = 1'b1;
      end
    end
  end

endmodule

// File: rtl/id_forward_scoreboard.sv
// Decode-stage hazard and forwarding unit: a shifting scoreboard of in-flight writes,
// per-port operand resolution, load-use stall generation and a saturating stall counter.
module id_forward_scoreboard
  import id_forward_scoreboard_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2,
  parameter int DEPTH  = 3,
  parameter int LAT_W  = 2,
  parameter int CNT_W  = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     id_valid,
  input  logic                     id_wen,
  input  logic [ADDR_W-1:0]        id_dst,
  input  logic [LAT_W-1:0]         id_ready_slot,
  input  logic [NUM_RD-1:0]        rd_en,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  input  logic [NUM_RD*DATA_W-1:0] rf_data,
  input  logic [DEPTH*DATA_W-1:0]  stage_data,
  input  logic [DEPTH-1:0]         flush_mask,
  input  logic                     cnt_clr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_fwd,
  output logic                     stall,
  output logic [CNT_W-1:0]         stall_cnt
);

  sbEntry_t [DEPTH-1:0] sb;
  logic [NUM_RD-1:0]    portHazard;
  logic                 doInsert;

  assign doInsert = id_valid && id_wen && (id_dst != '0) && !stall;
  assign stall    = |portHazard;

  for (genvar r = 0; r < NUM_RD; r++) begin : g_port
    fwd_port_resolve #(
      .DATA_W(DATA_W),
      .ADDR_W(ADDR_W),
      .DEPTH (DEPTH)
    ) u_resolve (
      .en       (rd_en[r]),
      .addr     (rd_addr[r*ADDR_W +: ADDR_W]),
      .rfData   (rf_data[r*DATA_W +: DATA_W]),
      .stageData(stage_data),
      .entries  (sb),
      .data     (rd_data[r*DATA_W +: DATA_W]),
      .fwd      (rd_fwd[r]),
      .hazard   (portHazard[r])
    );
  end

  // NOTE: only the valid bits need clearing on reset; stale dst/rdy behind a cleared
  // valid bit can never match, but clearing the whole entry keeps simulation X-free.
  always_ff @(posedge clk) begin
    if (rst) begin
      sb        <= '0;
      stall_cnt <= '0;
    end else begin
      // NOTE: non-blocking updates let every slot sample its upstream neighbour's old value.
      sb[SLOT_EX] <= makeEntry(doInsert && !flush_mask[SLOT_EX],
                               SB_ADDR_W'(id_dst), SB_LAT_W'(id_ready_slot));
      for (int k = 1; k < DEPTH; k++) begin
        sb[k]       <= sb[k-1];
        sb[k].valid <= sb[k-1].valid && !flush_mask[k];
      end

      if (cnt_clr) begin
        stall_cnt <= '0;
      end else if (stall && stall_cnt != {CNT_W{1'b1}}) begin
        stall_cnt <= stall_cnt + 1'b1;
      end
    end
  end

endmodule
